fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

- Sequences the fetch stage of the P7 CPU.
- Decides each cycle whether the IFU PC register advances, and to what:
  - PC+4 on a completed fetch;
  - branch/jump target;
  - exception entry;
  - EPC on eret.
- Runs the req/ack handshake with the multi-cycle instruction bus and holds the fetched word in a one-entry output buffer for the D stage.
- Sits between the IFU PC register, the instruction bus, the D stage and CP0.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; IFU resets to the same value.
- EXC_ENTRY, 32'h0000_4180, exception/interrupt handler address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- PC  in  32  current PC from IFU.
- PC_We  out  1  IFU write enable, combinational.
- NPC  out  32  IFU next PC, combinational.
- Ifetch_Req  out  1  bus request, registered.
- Ifetch_Addr  out  32  bus address, registered, held while Ifetch_Req=1.
- Ifetch_Ack  in  1  bus completion; Ifetch_Data is valid in the same cycle.
- Ifetch_Data  in  32  fetched word.
- Instr_Valid  out  1  output buffer full.
- Instr  out  32  buffered instruction.
- Instr_PC  out  32  address of the buffered instruction.
- AdEL  out  1  buffered entry is a fetch address fault.
- Instr_Ready  in  1  D stage consumes the buffer this cycle when Instr_Valid=1.
- Br_Redirect  in  1  one-cycle pulse: branch/jump taken.
- Br_Target  in  32  target for Br_Redirect.
- Exc_Redirect  in  1  one-cycle pulse from CP0: exception or interrupt.
- Eret  in  1  one-cycle pulse: eret executed.
- EPC  in  32  return address for Eret.

## Operation
State machine has three states.

- IDLE: Ifetch_Req=0.
  - Go to REQ when all of the following hold: no redirect this cycle; the buffer will be empty next cycle (empty now, or full with Instr_Ready=1); PC is legal.
  - Ifetch_Addr <= PC on that edge.
- REQ: Ifetch_Req=1; Ifetch_Addr is frozen until Ack.
  - On Ack with no redirect live (pending or this cycle): load buffer (Instr=Ifetch_Data, Instr_PC=Ifetch_Addr, AdEL=0); PC_We=1, NPC=PC+4; go to IDLE.
  - On Ack with a redirect live: discard data, buffer not loaded; PC_We=1, NPC=redirect target; clear pending; go to IDLE.
  - A redirect without Ack: record pending target; Req stays high. The latest redirect overwrites any earlier pending one.
- FAULT: entered from IDLE instead of REQ when PC is illegal (PC[1:0]!=0, PC<IM_BASE or PC>IM_LIMIT).
  - On entry, buffer loads Instr=0, Instr_PC=PC, AdEL=1; no request; PC_We=0.
  - Stays in FAULT until a redirect arrives: PC_We=1, NPC=target, go to IDLE.

Rules that apply in every state:
- Redirect target, same-cycle priority: Exc_Redirect (EXC_ENTRY) > Eret (EPC) > Br_Redirect (Br_Target).
- Any redirect flushes the buffer: Instr_Valid=0 next cycle, regardless of Instr_Ready.
- A redirect in IDLE or FAULT takes effect in the same cycle: PC_We=1, NPC=target.
- Buffer:
  - cleared when Instr_Valid=1 and Instr_Ready=1 with no load that cycle;
  - holds its contents while Instr_Ready=0;
  - never overwritten while full.
- PC+4 is modulo 2^32.
- When PC_We=0, NPC=PC+4; the value is don't-care to IFU.

## Timing
- Reset (async, Rst_n=0) forces:
  - state IDLE, pending cleared;
  - Ifetch_Req=0, Ifetch_Addr=0;
  - Instr_Valid=0, Instr=0, Instr_PC=0, AdEL=0;
  - PC_We=0, NPC=PC+4.
- Reset mid-request drops Ifetch_Req immediately; a late Ack is ignored.
- First request: Ifetch_Req rises on the first edge after Rst_n deasserts, with Ifetch_Addr=PC (RESET_PC).
- Fetch with Ack in cycle N:
  - PC_We=1 in cycle N; IFU PC updates at edge N+1;
  - Instr_Valid=1 from cycle N+1;
  - next Req no earlier than N+2.
- Peak throughput: one instruction per 2 cycles plus bus wait.
- Redirect in IDLE at cycle N: PC=target at N+1; Req with Ifetch_Addr=target at N+2.

## Test plan
- Reset, Ack 1 cycle after each Req, Instr_Ready=1 -> Instr_PC sequence 0x3000, 0x3004, 0x3008 with one-cycle Req gaps; Instr equals bus data.
- Instr_Ready=0 for 5 cycles while Instr_Valid=1 -> Instr/Instr_PC stable, no new Req; Ready=1 -> next Req the following cycle.
- Br_Redirect (target 0x3100) 2 cycles before a 4-cycle-latency Ack -> Ifetch_Addr unchanged until Ack, data discarded, PC=0x3100, next Req address 0x3100.
- Exc_Redirect, Eret (EPC=0x3040) and Br_Redirect (0x3200) in the same IDLE cycle -> NPC=0x4180, buffer flushed.
- Br_Target=0x3002 -> no Req; Instr_Valid=1, AdEL=1, Instr=0, Instr_PC=0x3002; Exc_Redirect -> PC=0x4180, fetch resumes.
- Rst_n low during outstanding Req, then Ack asserted -> Req=0 immediately, Ack ignored, all outputs at reset values; restart at 0x3000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Fetch-stage sequencer for the P7 CPU. Each cycle it decides whether the
//   IFU PC register is written and with what value: PC+4 after a completed
//   fetch, a branch/jump target, the exception entry, or EPC on eret. It runs
//   the req/ack handshake with the multi-cycle instruction bus and holds the
//   fetched word in a one-entry buffer for the D stage.
//
// Ports
//   Clk, Rst_n            clock (rising edge), asynchronous active-low reset
//   PC                    current PC from IFU
//   PC_We, NPC            IFU write enable / next PC (combinational)
//   Ifetch_Req/Addr       bus request and address (registered)
//   Ifetch_Ack/Data       bus completion and fetched word (same cycle)
//   Instr_Valid/Instr/
//   Instr_PC/AdEL         output buffer towards the D stage
//   Instr_Ready           D stage consumes the buffer this cycle
//   Br_Redirect/Br_Target branch/jump taken pulse and target
//   Exc_Redirect          exception/interrupt pulse from CP0
//   Eret/EPC              eret pulse and return address
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] PC,
  output logic        PC_We,
  output logic [31:0] NPC,
  output logic        Ifetch_Req,
  output logic [31:0] Ifetch_Addr,
  input  logic        Ifetch_Ack,
  input  logic [31:0] Ifetch_Data,
  output logic        Instr_Valid,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic        AdEL,
  input  logic        Instr_Ready,
  input  logic        Br_Redirect,
  input  logic [31:0] Br_Target,
  input  logic        Exc_Redirect,
  input  logic        Eret,
  input  logic [31:0] EPC
);

  // The IFU owns the reset PC; it is only recorded here as a sanity flag that
  // the reset vector lies inside the fetchable window.
  localparam bit unused_reset_pc_ok = (RESET_PC[1:0] == 2'b00) &&
                                      (RESET_PC >= IM_BASE) && (RESET_PC <= IM_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FAULT} state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_pend;
  logic [31:0] r_pend_tgt;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_adel;

  logic        w_redir;
  logic [31:0] w_redir_tgt;
  logic [31:0] w_pc_inc;
  logic        w_pc_legal;
  logic        w_buf_free;
  logic        w_ack;
  logic        w_load_fetch;
  logic        w_load_fault;

  assign w_redir     = Exc_Redirect | Eret | Br_Redirect;
  assign w_redir_tgt = Exc_Redirect ? EXC_ENTRY : (Eret ? EPC : Br_Target);
  assign w_pc_inc    = PC + 32'd4;
  assign w_pc_legal  = (PC[1:0] == 2'b00) && (PC >= IM_BASE) && (PC <= IM_LIMIT);
  // Buffer is guaranteed empty on the next cycle
  assign w_buf_free  = !r_valid || Instr_Ready;
  assign w_ack       = (r_state == S_REQ) && Ifetch_Ack;
  // A redirect that is pending or arrives with the Ack kills the fetched word
  assign w_load_fetch = w_ack && !w_redir && !r_pend;
  assign w_load_fault = (r_state == S_IDLE) && !w_redir && w_buf_free && !w_pc_legal;

  // PC update: IDLE/FAULT honour a redirect at once; REQ only moves PC on Ack
  always_comb begin
    PC_We = 1'b0;
    NPC   = w_pc_inc;
    if (r_state == S_REQ) begin
      if (Ifetch_Ack) begin
        PC_We = 1'b1;
        if (w_redir)     NPC = w_redir_tgt;
        else if (r_pend) NPC = r_pend_tgt;
      end
    end else if (w_redir) begin
      PC_We = 1'b1;
      NPC   = w_redir_tgt;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= 32'd0;
      r_pend     <= 1'b0;
      r_pend_tgt <= 32'd0;
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_instr_pc <= 32'd0;
      r_adel     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_redir && w_buf_free) begin
            if (w_pc_legal) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_addr  <= PC;
            end else begin
              r_state <= S_FAULT;
            end
          end
        end
        S_REQ: begin
          if (Ifetch_Ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_pend  <= 1'b0;
          end else if (w_redir) begin
            // Newest redirect wins over any earlier pending one
            r_pend     <= 1'b1;
            r_pend_tgt <= w_redir_tgt;
          end
        end
        S_FAULT: begin
          if (w_redir) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase

      // Output buffer: flush beats load beats consume
      if (w_redir) begin
        r_valid <= 1'b0;
      end else if (w_load_fetch) begin
        r_valid    <= 1'b1;
        r_instr    <= Ifetch_Data;
        r_instr_pc <= r_addr;
        r_adel     <= 1'b0;
      end else if (w_load_fault) begin
        r_valid    <= 1'b1;
        r_instr    <= 32'd0;
        r_instr_pc <= PC;
        r_adel     <= 1'b1;
      end else if (r_valid && Instr_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign Ifetch_Req  = r_req;
  assign Ifetch_Addr = r_addr;
  assign Instr_Valid = r_valid;
  assign Instr       = r_instr;
  assign Instr_PC    = r_instr_pc;
  assign AdEL        = r_adel;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] ifu_pc;
  logic        PC_We;
  logic [31:0] NPC;
  logic        Ifetch_Req;
  logic [31:0] Ifetch_Addr;
  logic        Ifetch_Ack;
  logic [31:0] Ifetch_Data;
  logic        Instr_Valid;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        AdEL;
  logic        Instr_Ready;
  logic        Br_Redirect;
  logic [31:0] Br_Target;
  logic        Exc_Redirect;
  logic        Eret;
  logic [31:0] EPC;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  // IFU PC register as seen by the fetch controller
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     ifu_pc <= 32'h0000_3000;
    else if (PC_We) ifu_pc <= NPC;
  end

  fetch_ctrl dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .PC           (ifu_pc),
    .PC_We        (PC_We),
    .NPC          (NPC),
    .Ifetch_Req   (Ifetch_Req),
    .Ifetch_Addr  (Ifetch_Addr),
    .Ifetch_Ack   (Ifetch_Ack),
    .Ifetch_Data  (Ifetch_Data),
    .Instr_Valid  (Instr_Valid),
    .Instr        (Instr),
    .Instr_PC     (Instr_PC),
    .AdEL         (AdEL),
    .Instr_Ready  (Instr_Ready),
    .Br_Redirect  (Br_Redirect),
    .Br_Target    (Br_Target),
    .Exc_Redirect (Exc_Redirect),
    .Eret         (Eret),
    .EPC          (EPC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Called one cycle after Req is expected high; Ack arrives after lat cycles
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat);
    chkb("req_up", Ifetch_Req, 1'b1);
    chk("req_addr", Ifetch_Addr, addr);
    for (int i = 0; i < lat; i++) begin
      tick();
      chkb("req_hold", Ifetch_Req, 1'b1);
      chk("addr_hold", Ifetch_Addr, addr);
    end
    Ifetch_Ack  = 1'b1;
    Ifetch_Data = data;
    #1;
    chkb("ack_pcwe", PC_We, 1'b1);
    chk("ack_npc", NPC, addr + 32'd4);
    tick();
    Ifetch_Ack  = 1'b0;
    Ifetch_Data = 32'd0;
    chkb("req_drop", Ifetch_Req, 1'b0);
    chkb("buf_valid", Instr_Valid, 1'b1);
    chk("buf_instr", Instr, data);
    chk("buf_pc", Instr_PC, addr);
    chkb("buf_adel", AdEL, 1'b0);
  endtask

  initial begin
    Rst_n        = 1'b0;
    Ifetch_Ack   = 1'b0;
    Ifetch_Data  = 32'd0;
    Instr_Ready  = 1'b0;
    Br_Redirect  = 1'b0;
    Br_Target    = 32'd0;
    Exc_Redirect = 1'b0;
    Eret         = 1'b0;
    EPC          = 32'd0;
    tick();
    tick();

    // Reset state
    chkb("rst_req", Ifetch_Req, 1'b0);
    chk("rst_addr", Ifetch_Addr, 32'd0);
    chkb("rst_valid", Instr_Valid, 1'b0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_ipc", Instr_PC, 32'd0);
    chkb("rst_adel", AdEL, 1'b0);
    chkb("rst_pcwe", PC_We, 1'b0);
    chk("rst_npc", NPC, 32'h0000_3004);

    // Sequential fetch, Ack one cycle after Req, D stage always ready
    Rst_n       = 1'b1;
    Instr_Ready = 1'b1;
    tick();
    fetch(32'h0000_3000, 32'h8C01_0000, 1);
    tick();
    chkb("gap_consumed", Instr_Valid, 1'b0);
    fetch(32'h0000_3004, 32'h2402_0005, 1);
    tick();
    fetch(32'h0000_3008, 32'h0043_1820, 1);

    // Stall: D stage not ready for 5 cycles
    Instr_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chkb("stall_req", Ifetch_Req, 1'b0);
      chkb("stall_valid", Instr_Valid, 1'b1);
      chk("stall_instr", Instr, 32'h0043_1820);
      chk("stall_ipc", Instr_PC, 32'h0000_3008);
    end
    Instr_Ready = 1'b1;
    tick();
    chkb("resume_req", Ifetch_Req, 1'b1);
    chk("resume_addr", Ifetch_Addr, 32'h0000_300C);
    chkb("resume_consumed", Instr_Valid, 1'b0);

    // Branch while a 4-cycle fetch is outstanding
    tick();
    tick();
    Br_Redirect = 1'b1;
    Br_Target   = 32'h0000_3100;
    #1;
    chkb("br_req_pcwe", PC_We, 1'b0);
    tick();
    Br_Redirect = 1'b0;
    chkb("br_req_hold", Ifetch_Req, 1'b1);
    chk("br_addr_hold", Ifetch_Addr, 32'h0000_300C);
    tick();
    Ifetch_Ack  = 1'b1;
    Ifetch_Data = 32'hDEAD_BEEF;
    #1;
    chkb("br_ack_pcwe", PC_We, 1'b1);
    chk("br_ack_npc", NPC, 32'h0000_3100);
    tick();
    Ifetch_Ack  = 1'b0;
    Ifetch_Data = 32'd0;
    chkb("br_discard", Instr_Valid, 1'b0);
    chkb("br_req_low", Ifetch_Req, 1'b0);
    chk("br_pc", ifu_pc, 32'h0000_3100);
    tick();
    fetch(32'h0000_3100, 32'h1000_FFFF, 3);

    // Simultaneous exception, eret and branch in IDLE with a full buffer
    Instr_Ready  = 1'b0;
    Exc_Redirect = 1'b1;
    Eret         = 1'b1;
    EPC          = 32'h0000_3040;
    Br_Redirect  = 1'b1;
    Br_Target    = 32'h0000_3200;
    #1;
    chkb("prio_pcwe", PC_We, 1'b1);
    chk("prio_npc", NPC, 32'h0000_4180);
    tick();
    Exc_Redirect = 1'b0;
    Eret         = 1'b0;
    Br_Redirect  = 1'b0;
    chkb("prio_flush", Instr_Valid, 1'b0);
    chkb("prio_no_req", Ifetch_Req, 1'b0);
    chk("prio_pc", ifu_pc, 32'h0000_4180);
    tick();
    fetch(32'h0000_4180, 32'h4200_0018, 1);

    // Misaligned branch target -> address fault entry
    Br_Redirect = 1'b1;
    Br_Target   = 32'h0000_3002;
    #1;
    chkb("mis_pcwe", PC_We, 1'b1);
    chk("mis_npc", NPC, 32'h0000_3002);
    tick();
    Br_Redirect = 1'b0;
    chkb("mis_flush", Instr_Valid, 1'b0);
    chkb("mis_no_req", Ifetch_Req, 1'b0);
    tick();
    chkb("fault_no_req", Ifetch_Req, 1'b0);
    chkb("fault_valid", Instr_Valid, 1'b1);
    chkb("fault_adel", AdEL, 1'b1);
    chk("fault_instr", Instr, 32'd0);
    chk("fault_ipc", Instr_PC, 32'h0000_3002);
    chkb("fault_pcwe", PC_We, 1'b0);
    tick();
    chkb("fault_stay_req", Ifetch_Req, 1'b0);
    chkb("fault_stay_valid", Instr_Valid, 1'b1);
    Exc_Redirect = 1'b1;
    #1;
    chkb("fault_exc_pcwe", PC_We, 1'b1);
    chk("fault_exc_npc", NPC, 32'h0000_4180);
    tick();
    Exc_Redirect = 1'b0;
    chkb("fault_exit_valid", Instr_Valid, 1'b0);
    chkb("fault_exit_req", Ifetch_Req, 1'b0);
    tick();
    chkb("refetch_req", Ifetch_Req, 1'b1);
    chk("refetch_addr", Ifetch_Addr, 32'h0000_4180);

    // Reset during an outstanding request, then a late Ack
    tick();
    Rst_n = 1'b0;
    #1;
    chkb("mrst_req", Ifetch_Req, 1'b0);
    chk("mrst_addr", Ifetch_Addr, 32'd0);
    chkb("mrst_pcwe", PC_We, 1'b0);
    chk("mrst_npc", NPC, 32'h0000_3004);
    Ifetch_Ack  = 1'b1;
    Ifetch_Data = 32'h1234_5678;
    tick();
    chkb("late_ack_valid", Instr_Valid, 1'b0);
    chk("late_ack_instr", Instr, 32'd0);
    chk("late_ack_ipc", Instr_PC, 32'd0);
    chkb("late_ack_req", Ifetch_Req, 1'b0);
    Ifetch_Ack  = 1'b0;
    Ifetch_Data = 32'd0;
    Rst_n       = 1'b1;
    Instr_Ready = 1'b1;
    tick();
    fetch(32'h0000_3000, 32'hAC05_0004, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
